// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB command master.
// State encodings and width helpers used by the master and its timer.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_state_e;

    // One strobe bit per byte lane.
    function automatic int unsigned apb_strb_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // Timer width able to hold 0..TIMEOUT; one bit when disabled.
    function automatic int unsigned apb_cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_access_timer.sv
// ACCESS-phase wait counter for the APB command master.
// Flags the last allowed wait cycle; saturates; inert when TIMEOUT is 0.
module apb_access_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = apb_cnt_width(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
            localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Next count: clear wins, then a saturating increment.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && (cnt_q != MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Count register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired_o = (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: one valid/ready command becomes one APB transfer.
// Response carries read data and slave-error / timeout status.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned STRB_W = apb_strb_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB requester
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [STRB_W-1:0] pstrb,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    // Timer restarts in SETUP and counts ACCESS cycles still waiting.
    assign tmr_clear  = (state_q == APB_SETUP);
    assign tmr_enable = (state_q == APB_ACCESS) && !pready;

    apb_access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    // Next-state and datapath: everything holds unless a phase moves it.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pstrb_d     = pstrb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            APB_IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = APB_SETUP;
                end
            end
            APB_SETUP: begin
                penable_d = 1'b1;
                state_d   = APB_ACCESS;
            end
            APB_ACCESS: begin
                // A late pready on the last allowed cycle still completes.
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    rsp_valid_d = 1'b1;
                    state_d     = APB_RESP;
                end else if (tmr_expired) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = APB_RESP;
                end
            end
            APB_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = APB_IDLE;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= APB_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == APB_IDLE);
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign pstrb     = pstrb_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
